// File: rtl/counter_slot_arbiter.sv
// Round-robin arbiter that lends one shared clearable up-counter to a
// single requester at a time for a slot of len ticks, then pulses done.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no slot active; pick next requester round-robin from ptr
// S_CLEAR | grant issued; clear the shared counter for one cycle
// S_RUN   | counter enabled until it reaches the latched length
// S_DONE  | one-cycle done pulse to the granted requester
module counter_slot_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 4,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] req_len,
    input  logic [CNT_W-1:0]         cnt_value,
    output logic                     cnt_en,
    output logic                     cnt_clr,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [ID_W-1:0]          gnt_id,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [NUM_REQ-1:0]   done_q;
    logic [ID_W-1:0]      id_q;
    logic [ID_W-1:0]      ptr_q;
    logic [CNT_W-1:0]     len_q;

    logic                 win_vld_d;
    logic [ID_W-1:0]      win_id_d;
    logic [ID_W-1:0]      ptr_nxt_d;

    // First pending request at or above ptr, wrapping modulo NUM_REQ.
    always_comb begin
        logic [ID_W:0] idx;
        idx       = '0;
        win_vld_d = 1'b0;
        win_id_d  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NUM_REQ)) begin
                idx = idx - (ID_W+1)'(NUM_REQ);
            end
            if (!win_vld_d && req[idx[ID_W-1:0]]) begin
                win_vld_d = 1'b1;
                win_id_d  = idx[ID_W-1:0];
            end
        end
    end

    // Pointer moves past the current owner whether the slot completed or was abandoned.
    always_comb begin
        ptr_nxt_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
    end

    // Slot sequencing FSM with registered grant, id and done.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            len_q   <= '0;
        end else begin
            done_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (win_vld_d) begin
                        state_q <= S_CLEAR;
                        gnt_q   <= NUM_REQ'(1) << win_id_d;
                        id_q    <= win_id_d;
                        len_q   <= req_len[win_id_d*CNT_W +: CNT_W];
                    end
                end
                S_CLEAR: begin
                    if (!req[id_q]) begin
                        state_q <= S_IDLE;
                        gnt_q   <= '0;
                        ptr_q   <= ptr_nxt_d;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    // A dropped request wins even on the terminal-count cycle.
                    if (!req[id_q]) begin
                        state_q <= S_IDLE;
                        gnt_q   <= '0;
                        ptr_q   <= ptr_nxt_d;
                    end else if (cnt_value == len_q) begin
                        state_q <= S_DONE;
                        done_q  <= gnt_q;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    gnt_q   <= '0;
                    ptr_q   <= ptr_nxt_d;
                end
            endcase
        end
    end

    assign cnt_clr = (state_q == S_CLEAR);
    assign cnt_en  = (state_q == S_RUN) && (cnt_value != len_q);
    assign busy    = (state_q != S_IDLE);
    assign gnt     = gnt_q;
    assign gnt_id  = id_q;
    assign done    = done_q;

endmodule

// File: tb/tb_counter_slot_arbiter.sv
// Bench for counter_slot_arbiter: a shared counter model, a slot-timing
// reference model, directed scenarios and a randomized phase.
module tb_counter_slot_arbiter;

    localparam int NR = 4;
    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] req_len;
    logic [3:0]  cnt_value = 4'd9;
    logic        cnt_en, cnt_clr, busy;
    logic [3:0]  gnt, done;
    logic [1:0]  gnt_id;

    always #5 clk = ~clk;

    counter_slot_arbiter #(.NUM_REQ(NR), .CNT_W(CW), .ID_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_len   (req_len),
        .cnt_value (cnt_value),
        .cnt_en    (cnt_en),
        .cnt_clr   (cnt_clr),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .done      (done),
        .busy      (busy)
    );

    // Shared counter: clear has priority over enable.
    always @(posedge clk) begin
        if (cnt_clr === 1'b1)     cnt_value <= 4'd0;
        else if (cnt_en === 1'b1) cnt_value <= cnt_value + 4'd1;
    end

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Reference: a slot is (owner, length, offset t); t=0 clear, 1..L count,
    // L+1 terminal compare, L+2 done. Otherwise idle.
    int m_active = 0;
    int m_id     = 0;
    int m_len    = 0;
    int m_t      = 0;
    int m_ptr    = 0;
    bit auto_drop = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [1:0] idx;
        bit         found;
        if (reset !== 1'b1) begin
            m_active = 0;
            m_ptr    = 0;
        end else if (m_active != 0) begin
            if (m_t <= m_len + 1 && req[2'(m_id)] == 1'b0) begin
                m_active = 0;
                m_ptr    = (m_id + 1) % NR;
            end else if (m_t == m_len + 2) begin
                m_active = 0;
                m_ptr    = (m_id + 1) % NR;
            end else begin
                m_t++;
            end
        end else if (req != 4'd0) begin
            found = 1'b0;
            for (int k = 0; k < NR; k++) begin
                idx = 2'((m_ptr + k) % NR);
                if (!found && req[idx]) begin
                    found = 1'b1;
                    m_id  = int'(idx);
                end
            end
            m_len    = int'(req_len[m_id*CW +: CW]);
            m_active = 1;
            m_t      = 0;
        end
    endtask

    task automatic check_outputs();
        logic [3:0] oh;
        oh = (m_active != 0) ? 4'(1 << m_id) : 4'd0;
        chk("gnt",     gnt,     oh);
        chk("busy",    busy,    (m_active != 0));
        chk("cnt_clr", cnt_clr, (m_active != 0) && m_t == 0);
        chk("cnt_en",  cnt_en,  (m_active != 0) && m_t >= 1 && m_t <= m_len);
        chk("done",    done,    (m_t == m_len + 2) ? oh : 4'd0);
        if (m_active != 0) chk("gnt_id", gnt_id, m_id);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_outputs();
        if (auto_drop && m_active != 0 && m_t == m_len + 2) req[2'(m_id)] = 1'b0;
    endtask

    task automatic run_slot(input int id, input int len, input string tag);
        int done_at;
        int en_cnt;
        done_at = -1;
        en_cnt  = 0;
        req_len[id*CW +: CW] = 4'(len);
        req[2'(id)] = 1'b1;
        for (int k = 1; k <= len + 6; k++) begin
            tick();
            if (done[2'(id)] === 1'b1 && done_at < 0) done_at = k;
            if (cnt_en === 1'b1) en_cnt++;
        end
        chk({tag, " done cycle"}, done_at, len + 3);
        chk({tag, " enable cycles"}, en_cnt, len);
    endtask

    int order[$];
    int clr_cyc[$];
    int lim;

    initial begin
        // Reset held with all requests up.
        reset   = 1'b0;
        req     = 4'b1111;
        req_len = 16'h1234;
        repeat (3) begin
            tick();
            chk("reset gnt_id", gnt_id, 0);
        end
        reset = 1'b1;
        req   = 4'd0;
        repeat (2) tick();

        run_slot(2, 5, "single");
        run_slot(0, 0, "zero len");
        run_slot(2, 15, "max len");

        // Fairness from ptr=0 with every requester continuously asking.
        reset = 1'b0;
        tick();
        reset     = 1'b1;
        auto_drop = 1'b0;
        req_len   = 16'h1111;
        req       = 4'b1111;
        repeat (25) begin
            tick();
            if (cnt_clr === 1'b1) begin
                order.push_back(int'(gnt_id));
                clr_cyc.push_back(cyc);
            end
        end
        req       = 4'd0;
        auto_drop = 1'b1;
        chk("fair grant count", order.size(), 5);
        for (int k = 0; k < order.size() && k < 5; k++) begin
            chk("fair order", order[k], k % 4);
            if (k > 0) chk("fair period", clr_cyc[k] - clr_cyc[k-1], 5);
        end
        repeat (2) tick();

        // Abandon: requester 1 drops at count 3; pending 3 goes next.
        req_len[4 +: 4]  = 4'd10;
        req_len[12 +: 4] = 4'd2;
        req = 4'b1010;
        lim = 0;
        while (!(m_active != 0 && m_id == 1 && m_t == 4) && lim < 20) begin
            tick();
            lim++;
        end
        chk("abandon reach count", cnt_value, 4'd3);
        req[1] = 1'b0;
        tick();
        chk("abandon gnt", gnt, 4'd0);
        chk("abandon cnt_en", cnt_en, 1'b0);
        chk("abandon done", done, 4'd0);
        tick();
        chk("abandon next grant", gnt, 4'b1000);
        repeat (6) tick();

        // Reset in the middle of a running slot.
        req_len[4 +: 4]  = 4'd12;
        req_len[12 +: 4] = 4'd1;
        req = 4'b1010;
        lim = 0;
        while (!(m_active != 0 && m_id == 1 && m_t == 8) && lim < 20) begin
            tick();
            lim++;
        end
        chk("midreset reach count", cnt_value, 4'd7);
        reset = 1'b0;
        tick();
        chk("midreset gnt", gnt, 4'd0);
        chk("midreset busy", busy, 1'b0);
        chk("midreset en", cnt_en, 1'b0);
        chk("midreset clr", cnt_clr, 1'b0);
        reset = 1'b1;
        tick();
        chk("post reset first grant", gnt, 4'b0010);
        repeat (40) tick();

        // Randomized traffic, including abandons, length changes after grant
        // and occasional resets.
        repeat (700) begin
            for (int i = 0; i < NR; i++) begin
                if (req[2'(i)] == 1'b0) begin
                    if ($urandom_range(3) == 0) begin
                        req[2'(i)] = 1'b1;
                        req_len[i*CW +: CW] = 4'($urandom_range(0, 15));
                    end
                end else if (m_active != 0 && m_id == i) begin
                    if ($urandom_range(39) == 0) req[2'(i)] = 1'b0;
                    if ($urandom_range(3) == 0) req_len[i*CW +: CW] = 4'($urandom_range(0, 15));
                end else if ($urandom_range(15) == 0) begin
                    req[2'(i)] = 1'b0;
                end
            end
            reset = ($urandom_range(199) != 0);
            tick();
        end

        reset = 1'b1;
        req   = 4'd0;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/counter_slot_arbiter.md
Name: counter_slot_arbiter

Overview:
- Round-robin scheduler that shares one 4-bit up-counter (enable-driven, clearable) among NUM_REQ requesters.
- Each requester asks for a timed slot of len counter ticks. The arbiter grants one requester, clears the counter, enables it until it reaches len, then pulses done to that requester.
- Sits between the requesting blocks and the shared counter datapath. It is the only driver of the counter's enable and clear.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- CNT_W, 4, counter width and per-request length width
- ID_W, 2, width of gnt_id, equal to clog2(NUM_REQ)

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-low reset
- req  input  NUM_REQ  per-requester slot request, level; held until done or abandoned
- req_len  input  NUM_REQ*CNT_W  requested length; slice i is [i*CNT_W +: CNT_W]
- cnt_value  input  CNT_W  current value of the shared counter
- cnt_en  output  1  counter enable (increment on the next edge)
- cnt_clr  output  1  counter clear to 0 on the next edge; takes priority over cnt_en in the counter
- gnt  output  NUM_REQ  one-hot grant, registered
- gnt_id  output  ID_W  index of the granted requester; valid while busy=1
- done  output  NUM_REQ  one-cycle one-hot completion pulse
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset=0 sampled at an edge):
  - state=IDLE, gnt=0, gnt_id=0, done=0, cnt_en=0, cnt_clr=0, busy=0
  - rr pointer=0, latched length=0
  - Overrides everything, including mid-slot: the slot is dropped with no done pulse.
- States: IDLE, CLEAR, RUN, DONE. cnt_en and cnt_clr are decoded from the state.
- IDLE:
  - With any req bit high, select the first set bit searching upward from ptr, wrapping modulo NUM_REQ.
  - Latch the winner's req_len slice and id, set gnt one-hot and gnt_id, go to CLEAR.
  - With no request, stay in IDLE.
- CLEAR: cnt_clr=1 for exactly one cycle, cnt_en=0, then go to RUN.
- RUN:
  - cnt_en = (cnt_value != len_latched).
  - When cnt_value == len_latched: cnt_en=0, go to DONE.
- DONE:
  - Registered done[id]=1 for one cycle.
  - gnt clears on exit, ptr=(id+1) mod NUM_REQ, go to IDLE.
- Timing with req sampled in IDLE at edge n, length L:
  - CLEAR in cycle n+1, cnt_value=0 at n+2, cnt_value=L at n+2+L.
  - done high in cycle n+3+L; gnt high from n+1 through n+3+L.
  - Earliest next grant: the IDLE cycle after DONE, i.e. at least one idle cycle between slots.
- L=0: RUN detects the match immediately; done at n+3, no cnt_en cycles.
- L=2^CNT_W-1: counter never wraps; the slot lasts 2^CNT_W+2 cycles.
- Abandon:
  - Applies if the granted requester's req drops while in CLEAR or RUN.
  - Go to IDLE next cycle with gnt=0 and no done pulse; ptr=(id+1) mod NUM_REQ.
  - cnt_en=0 from that cycle on.
- Sampling rules:
  - req_len changes after grant are ignored.
  - Requests from non-granted requesters are ignored until IDLE.
  - Requests arriving during DONE are evaluated in the following IDLE cycle.
- Invariants:
  - cnt_en and cnt_clr never high together.
  - gnt is at most one-hot; done is at most one-hot.
  - done[i] only follows gnt[i].

Test Plan:
- Reset: hold reset=0 for 3 cycles with req=4'b1111 → gnt=0, done=0, cnt_en=0, cnt_clr=0, busy=0 throughout.
- Single slot: req[2]=1, len2=5 at edge n → gnt=4'b0100 and gnt_id=2 from n+1; cnt_clr=1 only in n+1; cnt_en high n+2..n+6; done=4'b0100 only in n+8.
- Zero length: req[0]=1, len0=0 → done[0] at n+3, cnt_en never asserted.
- Fairness: req=4'b1111 held continuously (re-raised after each done), all len=1 → grant order 0,1,2,3,0; each slot 4 cycles plus 1 IDLE cycle.
- Abandon: req[1], len=10; drop req[1] at cnt_value=3 → next cycle gnt=0, cnt_en=0, no done; pending req[3] granted next (ptr=2 skips to 3).
- Mid-slot reset: reset=0 during RUN at cnt_value=7 → next cycle all outputs at reset values; after release, req[1] pending is granted first (ptr=0, req[0] low).
